// File: rtl/wb_trig_poller.sv
// Autonomous Wishbone initiator for the trigger/echo sensor slave: one Set_Trig write, then periodic echo reads.
// Optional 4-sample moving average on dist_o when WB_TRIG_POLLER_AVG_EN is defined.
module wb_trig_poller #(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int unsigned POLL_CYCLES = 50000,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [8:0]  TRIG_CFG    = 9'h002
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [8:0]  cfg_i,
  input  logic        cfg_load,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  output logic [15:0] dist_o,
  output logic        dist_valid_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam int unsigned PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [7:0]    TO_LAST   = 8'(TIMEOUT);

  logic [1:0]    state_q;
  logic [8:0]    cfg_q;
  logic          cfg_pending_q;
  logic          cfg_reloaded_q;
  logic [PW-1:0] poll_cnt_q;
  logic [7:0]    to_cnt_q;
  logic          cyc_q, stb_q, we_q;
  logic [31:0]   adr_q, dat_q;
  logic [3:0]    sel_q;
  logic [15:0]   dist_q;
  logic          dist_valid_q;
  logic          err_q;

  logic [15:0]   sample;
  logic [15:0]   sample_next;
  logic          rd_done;
  logic          unused_hi;

  assign sample    = m_dat_i[15:0];
  assign unused_hi = ^m_dat_i[31:16];
  assign rd_done   = (state_q == S_RD) && stb_q && m_ack_i;

`ifdef WB_TRIG_POLLER_AVG_EN
  logic [15:0] tap1_q, tap2_q, tap3_q;
  logic        primed_q;
  logic [17:0] avg_sum;

  assign avg_sum     = 18'(sample) + 18'(tap1_q) + 18'(tap2_q) + 18'(tap3_q);
  assign sample_next = primed_q ? avg_sum[17:2] : sample;

  // First sample after reset fills every tap so the average starts at that value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap1_q   <= '0;
      tap2_q   <= '0;
      tap3_q   <= '0;
      primed_q <= 1'b0;
    end else if (rd_done) begin
      tap1_q   <= sample;
      tap2_q   <= primed_q ? tap1_q : sample;
      tap3_q   <= primed_q ? tap2_q : sample;
      primed_q <= 1'b1;
    end
  end
`else
  assign sample_next = sample;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cfg_q          <= TRIG_CFG;
      cfg_pending_q  <= 1'b1;
      cfg_reloaded_q <= 1'b0;
      poll_cnt_q     <= '0;
      to_cnt_q       <= '0;
      cyc_q          <= 1'b0;
      stb_q          <= 1'b0;
      we_q           <= 1'b0;
      adr_q          <= '0;
      sel_q          <= '0;
      dat_q          <= '0;
      dist_q         <= '0;
      dist_valid_q   <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      dist_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) state_q <= cfg_pending_q ? S_WR : S_RD;
        end
        S_WR, S_RD: begin
          if (!stb_q) begin
            // Launch: bus fields are latched here and held until ack or timeout.
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            sel_q    <= 4'hF;
            to_cnt_q <= 8'd1;
            if (state_q == S_WR) begin
              we_q           <= 1'b1;
              adr_q          <= BASE_ADR;
              dat_q          <= {23'b0, cfg_q};
              cfg_reloaded_q <= 1'b0;
            end else begin
              we_q  <= 1'b0;
              adr_q <= BASE_ADR + 32'd4;
              dat_q <= '0;
            end
          end else if (m_ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            sel_q <= '0;
            dat_q <= '0;
            if (state_q == S_WR) begin
              // A cfg_load seen during this write keeps the request pending.
              cfg_pending_q <= cfg_reloaded_q;
              if (enable) begin
                state_q <= S_RD;
              end else begin
                state_q    <= S_WAIT;
                poll_cnt_q <= '0;
              end
            end else begin
              dist_q       <= sample_next;
              dist_valid_q <= 1'b1;
              state_q      <= S_WAIT;
              poll_cnt_q   <= '0;
            end
          end else if (to_cnt_q == TO_LAST) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            sel_q      <= '0;
            dat_q      <= '0;
            err_q      <= 1'b1;
            state_q    <= S_WAIT;
            poll_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end
        S_WAIT: begin
          if (poll_cnt_q == POLL_LAST) begin
            if (!enable)           state_q <= S_IDLE;
            else if (cfg_pending_q) state_q <= S_WR;
            else                    state_q <= S_RD;
          end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (cfg_load) begin
        cfg_q          <= cfg_i;
        cfg_pending_q  <= 1'b1;
        cfg_reloaded_q <= 1'b1;
        err_q          <= 1'b0;
      end
    end
  end

  assign m_cyc_o      = cyc_q;
  assign m_stb_o      = stb_q;
  assign m_we_o       = we_q;
  assign m_adr_o      = adr_q;
  assign m_sel_o      = sel_q;
  assign m_dat_o      = dat_q;
  assign dist_o       = dist_q;
  assign dist_valid_o = dist_valid_q;
  assign busy_o       = cyc_q;
  assign err_o        = err_q;

endmodule
